// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths, arbiter state encoding and small helpers for the basereg write arbiter.
package rf_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [0:0] {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_t;

    // x0 is hardwired to zero, so any write aimed at it is a no-op.
    function automatic logic is_reg_write(input logic [REG_ADDR_W-1:0] addr);
        return (addr != {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Small queue of long-latency results awaiting a free basereg write slot.
// Each entry carries a live bit that a younger WB write to the same register can clear.
module rf_wr_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_addr,
    input  logic [XLEN-1:0]       push_data,
    input  logic                  pop,
    input  logic                  kill,
    input  logic [REG_ADDR_W-1:0] kill_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  empty_next,
    output logic                  head_live,
    output logic [REG_ADDR_W-1:0] head_addr,
    output logic [XLEN-1:0]       head_data,
    output logic                  any_live
);

    logic [REG_ADDR_W-1:0] addr_r [DEPTH];
    logic [XLEN-1:0]       data_r [DEPTH];
    logic [DEPTH-1:0]      live_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic [CNT_W-1:0]      count_next_s;
    logic [DEPTH-1:0]      live_next_s;
    logic [REG_ADDR_W-1:0] slot_addr_s [DEPTH];
    logic                  slot_base_s [DEPTH];

    assign full       = (count_r == CNT_W'(DEPTH));
    assign empty      = (count_r == {CNT_W{1'b0}});
    assign empty_next = (count_next_s == {CNT_W{1'b0}});
    assign head_live  = live_r[rd_ptr_r] & ~empty;
    assign head_addr  = addr_r[rd_ptr_r];
    assign head_data  = data_r[rd_ptr_r];
    assign any_live   = |live_r;

    // Next occupancy and live bits; the kill also sees an entry being pushed this cycle.
    always_comb begin
        count_next_s = count_r + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        live_next_s  = live_r;
        for (int i = 0; i < DEPTH; i++) begin
            slot_addr_s[i] = (push && (wr_ptr_r == PTR_W'(i))) ? push_addr : addr_r[i];
            slot_base_s[i] = (push && (wr_ptr_r == PTR_W'(i))) ? is_reg_write(push_addr) :
                             (pop  && (rd_ptr_r == PTR_W'(i))) ? 1'b0 : live_r[i];
            live_next_s[i] = slot_base_s[i] & ~(kill && (slot_addr_s[i] == kill_addr));
        end
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            live_r   <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= {REG_ADDR_W{1'b0}};
                data_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (push) begin
                addr_r[wr_ptr_r] <= push_addr;
                data_r[wr_ptr_r] <= push_data;
                wr_ptr_r         <= wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_next_s;
            live_r  <= live_next_s;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single basereg write port between WRITEBACK (always first) and queued
// long-latency results; a starving queue forces a pipeline stall until it drains.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wb_wr,
    input  logic [REG_ADDR_W-1:0] i_wb_addr,
    input  logic [XLEN-1:0]       i_wb_data,
    input  logic                  i_lu_valid,
    input  logic [REG_ADDR_W-1:0] i_lu_addr,
    input  logic [XLEN-1:0]       i_lu_data,
    output logic                  o_lu_ready,
    output logic                  o_wr_rd,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [XLEN-1:0]       o_rd,
    output logic                  o_stall,
    output logic                  o_pending
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t            state_r;
    arb_state_t            state_next_s;
    logic [STARVE_W-1:0]   starve_r;
    logic [STARVE_W-1:0]   starve_next_s;
    logic                  wr_rd_r;
    logic [REG_ADDR_W-1:0] rd_addr_r;
    logic [XLEN-1:0]       rd_r;
    logic                  stall_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  empty_next_s;
    logic                  head_live_s;
    logic [REG_ADDR_W-1:0] head_addr_s;
    logic [XLEN-1:0]       head_data_s;
    logic                  any_live_s;
    logic                  wb_write_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  head_write_s;
    logic                  sel_wr_s;
    logic [REG_ADDR_W-1:0] sel_addr_s;
    logic [XLEN-1:0]       sel_data_s;

    rf_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (i_clk),
        .rst        (i_rst),
        .push       (push_s),
        .push_addr  (i_lu_addr),
        .push_data  (i_lu_data),
        .pop        (pop_s),
        .kill       (wb_write_s),
        .kill_addr  (i_wb_addr),
        .full       (full_s),
        .empty      (empty_s),
        .empty_next (empty_next_s),
        .head_live  (head_live_s),
        .head_addr  (head_addr_s),
        .head_data  (head_data_s),
        .any_live   (any_live_s)
    );

    assign o_lu_ready = ~full_s;
    assign o_pending  = any_live_s;
    assign o_wr_rd    = wr_rd_r;
    assign o_rd_addr  = rd_addr_r;
    assign o_rd       = rd_r;
    assign o_stall    = stall_r;

    // Port selection: WB first, else a live head; dead heads leave without using the port.
    always_comb begin
        wb_write_s   = (state_r == ARB_NORMAL) && i_wb_wr && is_reg_write(i_wb_addr);
        push_s       = i_lu_valid & ~full_s;
        pop_s        = ~empty_s & (~head_live_s | ~wb_write_s);
        head_write_s = pop_s & head_live_s;
        sel_wr_s     = wb_write_s | head_write_s;
        if (wb_write_s) begin
            sel_addr_s = i_wb_addr;
            sel_data_s = i_wb_data;
        end else if (head_write_s) begin
            sel_addr_s = head_addr_s;
            sel_data_s = head_data_s;
        end else begin
            sel_addr_s = {REG_ADDR_W{1'b0}};
            sel_data_s = {XLEN{1'b0}};
        end
    end

    // Starve counter and NORMAL/FORCE next-state logic.
    always_comb begin
        starve_next_s = starve_r;
        state_next_s  = state_r;
        case (state_r)
            ARB_NORMAL: begin
                if (empty_s || pop_s) begin
                    starve_next_s = {STARVE_W{1'b0}};
                end else if (starve_r < STARVE_W'(STARVE_LIMIT)) begin
                    starve_next_s = starve_r + 1'b1;
                end else begin
                    starve_next_s = starve_r;
                end
                if (starve_next_s == STARVE_W'(STARVE_LIMIT)) begin
                    state_next_s = ARB_FORCE;
                end else begin
                    state_next_s = ARB_NORMAL;
                end
            end
            ARB_FORCE: begin
                starve_next_s = {STARVE_W{1'b0}};
                if (empty_next_s) begin
                    state_next_s = ARB_NORMAL;
                end else begin
                    state_next_s = ARB_FORCE;
                end
            end
            default: begin
                starve_next_s = {STARVE_W{1'b0}};
                state_next_s  = ARB_NORMAL;
            end
        endcase
    end

    // FSM state, counter and registered write-port/stall outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= ARB_NORMAL;
            starve_r  <= {STARVE_W{1'b0}};
            wr_rd_r   <= 1'b0;
            rd_addr_r <= {REG_ADDR_W{1'b0}};
            rd_r      <= {XLEN{1'b0}};
            stall_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            starve_r  <= starve_next_s;
            wr_rd_r   <= sel_wr_s;
            rd_addr_r <= sel_addr_s;
            rd_r      <= sel_data_s;
            stall_r   <= (state_next_s == ARB_FORCE);
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed table-driven bench for rf_write_arbiter plus starvation and reset-in-FORCE sequences.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_wr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        wr_rd;
    logic [4:0]  rd_addr;
    logic [31:0] rd;
    logic        stall;
    logic        pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wb_wr;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        lu_valid;
        logic [4:0]  lu_addr;
        logic [31:0] lu_data;
        logic        e_wr;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_stall;
        logic        e_ready;
        logic        e_pend;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    rf_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wb_wr    (wb_wr),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_data),
        .i_lu_valid (lu_valid),
        .i_lu_addr  (lu_addr),
        .i_lu_data  (lu_data),
        .o_lu_ready (lu_ready),
        .o_wr_rd    (wr_rd),
        .o_rd_addr  (rd_addr),
        .o_rd       (rd),
        .o_stall    (stall),
        .o_pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_wr, input logic [4:0] e_addr,
                           input logic [31:0] e_data, input logic e_stall,
                           input logic e_ready, input logic e_pend);
        chk({tag, ".wr_rd"},   {31'd0, wr_rd},    {31'd0, e_wr});
        chk({tag, ".rd_addr"}, {27'd0, rd_addr},  {27'd0, e_addr});
        chk({tag, ".rd"},      rd,                e_data);
        chk({tag, ".stall"},   {31'd0, stall},    {31'd0, e_stall});
        chk({tag, ".ready"},   {31'd0, lu_ready}, {31'd0, e_ready});
        chk({tag, ".pending"}, {31'd0, pending},  {31'd0, e_pend});
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic l, input logic [4:0] la, input logic [31:0] ld);
        @(negedge clk);
        wb_wr = w; wb_addr = wa; wb_data = wd;
        lu_valid = l; lu_addr = la; lu_data = ld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Inputs              wb wr/addr/data             lu valid/addr/data      | wr addr data           stall ready pend
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h11,   1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'h11,       1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 5'd1,  32'h100,      1'b1, 5'd2,  32'h22,   1'b1, 5'd1,  32'h100,      1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 5'd1,  32'h101,      1'b1, 5'd3,  32'h33,   1'b1, 5'd1,  32'h101,      1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 5'd1,  32'h102,      1'b1, 5'd4,  32'h44,   1'b1, 5'd1,  32'h102,      1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h44,   1'b1, 5'd2,  32'h22,       1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h44,   1'b1, 5'd3,  32'h33,       1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 5'd4,  32'h44,       1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'hAA,   1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 5'd9,  32'hBB,       1'b0, 5'd0,  32'h0,    1'b1, 5'd9,  32'hBB,       1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 5'd10, 32'hCC,       1'b1, 5'd10, 32'hDD,   1'b1, 5'd10, 32'hCC,       1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h55,   1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 5'd0,  32'h77,       1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'h66,   1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1};
        vecs[18] = '{1'b1, 5'd0,  32'h99,       1'b0, 5'd0,  32'h0,    1'b1, 5'd6,  32'h66,       1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        wb_wr = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        lu_valid = 1'b0; lu_addr = 5'd0; lu_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            drive(vecs[v].wb_wr, vecs[v].wb_addr, vecs[v].wb_data,
                  vecs[v].lu_valid, vecs[v].lu_addr, vecs[v].lu_data);
            chk_all($sformatf("vec%0d", v), vecs[v].e_wr, vecs[v].e_addr, vecs[v].e_data,
                    vecs[v].e_stall, vecs[v].e_ready, vecs[v].e_pend);
        end

        // Starvation: one entry queued while WB writes every cycle.
        drive(1'b1, 5'd1, 32'h200, 1'b1, 5'd12, 32'h1234);
        chk_all("starve_push", 1'b1, 5'd1, 32'h200, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 5'd1, 32'h200 + k, 1'b0, 5'd0, 32'h0);
            chk_all($sformatf("starve%0d", k), 1'b1, 5'd1, 32'h200 + k, (k == 8), 1'b1, 1'b1);
        end
        drive(1'b1, 5'd1, 32'h300, 1'b0, 5'd0, 32'h0);
        chk_all("force_drain", 1'b1, 5'd12, 32'h1234, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 5'd1, 32'h301, 1'b0, 5'd0, 32'h0);
        chk_all("after_force", 1'b1, 5'd1, 32'h301, 1'b0, 1'b1, 1'b0);

        // Reset asserted while FORCE holds a full queue.
        drive(1'b1, 5'd1, 32'h400, 1'b1, 5'd13, 32'h1313);
        drive(1'b1, 5'd1, 32'h401, 1'b1, 5'd14, 32'h1414);
        chk_all("fill2", 1'b1, 5'd1, 32'h401, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 5'd1, 32'h500 + k, 1'b0, 5'd0, 32'h0);
        end
        chk_all("force_full", 1'b1, 5'd1, 32'h506, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        wb_wr = 1'b0; lu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk_all("post_rst_idle", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk_all("post_rst_idle2", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
